// File: rtl/time_edit_ctrl.sv
// HH:MM:SS field editor between the button front-end and the clock core.
// Loads the live time on entry, edits six digit positions with auto-repeat, ends in COMMIT or CANCEL.
module time_edit_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 500,
    parameter int unsigned REPEAT_CYCLES  = 100,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [4:0]  BUTTONS,
    input  logic [17:0] LOAD_DATA,
    output logic [17:0] EDIT_DATA,
    output logic [2:0]  CURSOR,
    output logic        EDIT_ACTIVE,
    output logic        COMMIT,
    output logic        CANCEL
);

    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_CENTER = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0] UP_ONLY   = 5'b10000;
    localparam logic [4:0] DOWN_ONLY = 5'b01000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDIT = 2'd1,
        S_EXIT = 2'd2
    } state_t;

    state_t              state;
    logic [4:0]          btn_prev;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                rep_armed;
    logic                rep_phase;
    logic                held_up;

    logic [4:0]          press;
    logic                accept;
    logic                up_press;
    logic                dn_press;
    logic                center_press;
    logic                left_press;
    logic                right_press;
    logic                held_ok;
    logic [HOLD_W-1:0]   hold_target;
    logic                rep_hit;
    logic                step;
    logic                step_up;
    logic                activity;
    logic                timeout_hit;

    // Units digit: wraps at top; anything at or above top normalises to 0.
    function automatic logic [5:0] units_up(input logic [5:0] v, input logic [5:0] top);
        return (v >= top) ? 6'd0 : 6'(v + 6'd1);
    endfunction

    function automatic logic [5:0] units_dn(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : 6'(v - 6'd1);
    endfunction

    function automatic logic [5:0] ms_tens_up(input logic [5:0] v);
        return (v < 6'd50) ? 6'(v + 6'd10) : 6'(v - 6'd50);
    endfunction

    function automatic logic [5:0] ms_tens_dn(input logic [5:0] v);
        return (v >= 6'd10) ? 6'(v - 6'd10) : 6'(v + 6'd50);
    endfunction

    function automatic logic [5:0] hr_tens_up(input logic [5:0] v);
        return (v <= 6'd13) ? 6'(v + 6'd10) : 6'(v % 6'd10);
    endfunction

    // 0..3 jumps to 20..23, 4..9 to 14..19, so the result always stays a legal hour.
    function automatic logic [5:0] hr_tens_dn(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd10) begin
            r = 6'(v - 6'd10);
        end else if (v <= 6'd3) begin
            r = 6'(v + 6'd20);
        end else begin
            r = 6'(v + 6'd10);
        end
        return r;
    endfunction

    function automatic logic [17:0] edit_value(input logic [17:0] d, input logic [2:0] pos,
                                               input logic up);
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = d[17:12];
        m = d[11:6];
        s = d[5:0];
        case (pos)
            3'd0:    s = up ? units_up(s, 6'd59) : units_dn(s, 6'd59);
            3'd1:    s = up ? ms_tens_up(s)      : ms_tens_dn(s);
            3'd2:    m = up ? units_up(m, 6'd59) : units_dn(m, 6'd59);
            3'd3:    m = up ? ms_tens_up(m)      : ms_tens_dn(m);
            3'd4:    h = up ? units_up(h, 6'd23) : units_dn(h, 6'd23);
            3'd5:    h = up ? hr_tens_up(h)      : hr_tens_dn(h);
            default: ;
        endcase
        return {h, m, s};
    endfunction

    // Edge detection, one-hot press qualification and auto-repeat timing.
    always_comb begin
        press        = BUTTONS & ~btn_prev;
        accept       = (press != 5'd0) && ((press & 5'(press - 5'd1)) == 5'd0);
        up_press     = accept && press[BTN_UP];
        dn_press     = accept && press[BTN_DOWN];
        center_press = accept && press[BTN_CENTER];
        left_press   = accept && press[BTN_LEFT];
        right_press  = accept && press[BTN_RIGHT];
        held_ok      = rep_armed && (BUTTONS == (held_up ? UP_ONLY : DOWN_ONLY));
        hold_target  = rep_phase ? HOLD_W'(REPEAT_CYCLES - 1) : HOLD_W'(HOLD_CYCLES - 1);
        rep_hit      = held_ok && (hold_cnt == hold_target);
        step         = up_press || dn_press || rep_hit;
        step_up      = up_press ? 1'b1 : (dn_press ? 1'b0 : held_up);
        activity     = accept || rep_hit;
        timeout_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Editor state machine; all outputs registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            btn_prev    <= 5'd0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            rep_armed   <= 1'b0;
            rep_phase   <= 1'b0;
            held_up     <= 1'b0;
            EDIT_DATA   <= 18'd0;
            CURSOR      <= 3'd0;
            EDIT_ACTIVE <= 1'b0;
            COMMIT      <= 1'b0;
            CANCEL      <= 1'b0;
        end else begin
            btn_prev <= BUTTONS;
            COMMIT   <= 1'b0;
            CANCEL   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ENABLE) begin
                        state       <= S_EDIT;
                        EDIT_DATA   <= LOAD_DATA;
                        CURSOR      <= 3'd0;
                        EDIT_ACTIVE <= 1'b1;
                        to_cnt      <= '0;
                        hold_cnt    <= '0;
                        rep_armed   <= 1'b0;
                        rep_phase   <= 1'b0;
                    end
                end
                S_EDIT: begin
                    if (!ENABLE) begin
                        state       <= S_IDLE;
                        EDIT_ACTIVE <= 1'b0;
                        rep_armed   <= 1'b0;
                    end else if (center_press) begin
                        state       <= S_EXIT;
                        COMMIT      <= 1'b1;
                        EDIT_ACTIVE <= 1'b0;
                        rep_armed   <= 1'b0;
                    end else if (timeout_hit && !activity) begin
                        state       <= S_EXIT;
                        CANCEL      <= 1'b1;
                        EDIT_ACTIVE <= 1'b0;
                        rep_armed   <= 1'b0;
                    end else begin
                        if (step) begin
                            EDIT_DATA <= edit_value(EDIT_DATA, CURSOR, step_up);
                        end
                        if (left_press) begin
                            CURSOR <= (CURSOR == 3'd5) ? 3'd0 : 3'(CURSOR + 3'd1);
                        end else if (right_press) begin
                            CURSOR <= (CURSOR == 3'd0) ? 3'd5 : 3'(CURSOR - 3'd1);
                        end
                        // Repeat only while the button is held alone and unchanged.
                        if (up_press || dn_press) begin
                            rep_armed <= (BUTTONS == press);
                            held_up   <= up_press;
                            hold_cnt  <= '0;
                            rep_phase <= 1'b0;
                        end else if (held_ok) begin
                            if (rep_hit) begin
                                hold_cnt  <= '0;
                                rep_phase <= 1'b1;
                            end else begin
                                hold_cnt <= HOLD_W'(hold_cnt + 1'b1);
                            end
                        end else begin
                            rep_armed <= 1'b0;
                        end
                        to_cnt <= activity ? '0 : TO_W'(to_cnt + 1'b1);
                    end
                end
                S_EXIT: begin
                    if (!ENABLE) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    EDIT_ACTIVE <= 1'b0;
                end
            endcase
        end
    end

endmodule
